// File: rtl/rq_poly_add_seq.sv
// Rq coefficient adder (n=701, q=2^13): one pair per handshake through a 4-bit ripple chain.
// Define RQ_POLY_SUB_EN to add a sub_i port that selects (a-b) mod q for a whole frame.
//
// state   | meaning
// S_IDLE  | waiting for start_i, no pairs accepted
// S_RUN   | accepting pairs until coefficient N-1 is taken
// S_DRAIN | all pairs taken, waiting for the last result to be handed off

module adder4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
endmodule

module rq_poly_add_seq #(
  parameter int N      = 701,
  parameter int Q_BITS = 13,
  parameter int IDX_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef RQ_POLY_SUB_EN
  input  logic              sub_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [Q_BITS-1:0] in_a_i,
  input  logic [Q_BITS-1:0] in_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [Q_BITS-1:0] out_c_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o
);

  localparam int NCHUNK = (Q_BITS + 3) / 4;
  localparam int PAD_W  = NCHUNK * 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [Q_BITS-1:0] out_c_q, out_c_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              sub_q;

  logic accept;
  logic out_hs;
  logic start_ok;
  logic idx_at_last;

  // ---------------- datapath: ripple of 4-bit adders ----------------
  logic [PAD_W-1:0]  a_ext, b_ext, sum_full;
  logic [NCHUNK:0]   carry;
  logic [Q_BITS-1:0] sum;
  logic [PAD_W:0]    unused_sum_hi;

  assign a_ext    = PAD_W'(in_a_i);
  // Subtraction is a + ~b + 1 over the padded width; truncation keeps it mod q.
  assign b_ext    = sub_q ? ~PAD_W'(in_b_i) : PAD_W'(in_b_i);
  assign carry[0] = sub_q;

  for (genvar g = 0; g < NCHUNK; g++) begin : g_chain
    adder4bit u_add (
      .a_i    (a_ext[4*g +: 4]),
      .b_i    (b_ext[4*g +: 4]),
      .cin_i  (carry[g]),
      .s_o    (sum_full[4*g +: 4]),
      .cout_o (carry[g+1])
    );
  end

  assign sum           = sum_full[Q_BITS-1:0];
  assign unused_sum_hi = {carry[NCHUNK], sum_full};

  // ---------------- handshake terms ----------------
  assign idx_at_last = (idx_q == LAST_IDX);
  assign start_ok    = (state_q == S_IDLE) && start_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_q && out_ready_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && idx_at_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && out_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o     = 1'b0;
    in_ready_o = 1'b0;
    case (state_q)
      S_RUN: begin
        busy_o     = 1'b1;
        in_ready_o = !out_valid_q || out_ready_i;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o     = 1'b0;
        in_ready_o = 1'b0;
      end
    endcase
  end

  // ---------------- index and output register ----------------
  always_comb begin
    idx_d       = idx_q;
    out_c_d     = out_c_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    done_d      = (state_q == S_DRAIN) && out_hs && out_last_q;

    if (start_ok) begin
      idx_d = '0;
    end

    if (accept) begin
      out_c_d     = sum;
      out_idx_d   = idx_q;
      out_last_d  = idx_at_last;
      out_valid_d = 1'b1;
      if (!idx_at_last) idx_d = idx_q + IDX_W'(1);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      out_c_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_c_q     <= out_c_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef RQ_POLY_SUB_EN
  // Operation is frozen for the frame at the accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q <= 1'b0;
    end else if (start_ok) begin
      sub_q <= sub_i;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  assign out_c_o     = out_c_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_rq_poly_add_seq.sv
// Randomised bench for rq_poly_add_seq: queue-based reference of accepted pairs vs. handed-off results.
module tb_rq_poly_add_seq;
  localparam int N  = 701;
  localparam int QB = 13;
  localparam int IW = 10;
  localparam int Q  = 8192;

  logic          clk = 1'b0;
  logic          rst, start, sub;
  logic          busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [QB-1:0] in_a, in_b, out_c;
  logic [IW-1:0] out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int c; int idx; bit last;} res_t;
  res_t m_q[$];
  bit   m_active, m_ov, m_done, m_all_acc, m_sub;
  int   m_next, cyc, n_res, done_cnt, t_done;
  int   obs_c[N];
  int   t_hs[N];

  rq_poly_add_seq #(.N(N), .Q_BITS(QB), .IDX_W(IW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
`ifdef RQ_POLY_SUB_EN
    .sub_i       (sub),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_c_o     (out_c),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_op(input int a, input int b, input bit s);
    if (s) return ((a - b) % Q + Q) % Q;
    return (a + b) % Q;
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic cycle(input bit st, input bit iv, input int a, input int b, input bit ordy);
    bit   act0, acc, hs, exp_ir;
    int   oc;
    res_t it;
    @(negedge clk);
    start = st; in_valid = iv; in_a = QB'(a); in_b = QB'(b); out_ready = ordy;
    #1;
    exp_ir = m_active && !m_all_acc && (!m_ov || ordy);
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("in_ready", int'(in_ready), int'(exp_ir));
    if (m_ov) begin
      chk("out_c", int'(out_c), m_q[0].c);
      chk("out_idx", int'(out_idx), m_q[0].idx);
      chk("out_last", int'(out_last), int'(m_q[0].last));
    end
    if (done) begin
      done_cnt++;
      t_done = cyc;
    end
    oc   = int'(out_c);
    act0 = m_active;
    acc  = iv && exp_ir;
    hs   = m_ov && ordy;
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (hs) begin
      it = m_q.pop_front();
      obs_c[it.idx] = oc;
      t_hs[it.idx]  = cyc;
      n_res++;
      if (it.last) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    if (acc) begin
      m_q.push_back('{ref_op(a, b, m_sub), m_next, (m_next == N-1)});
      if (m_next == N-1) m_all_acc = 1'b1;
      else m_next++;
    end
    if (st && !act0) begin
      m_active = 1'b1; m_next = 0; m_all_acc = 1'b0; m_sub = sub;
    end
    m_ov = (m_q.size() != 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_done", int'(done), 0);
    m_q.delete();
    m_active = 0; m_ov = 0; m_done = 0; m_all_acc = 0; m_next = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0 wrap, 1 full-rate a=i b=2i, 2 backpressure at idx 10, 3 ignored start, 4 subtract
  task automatic run_frame(input int mode, input int rst_at);
    int budget, a, b, stall;
    bit iv, ordy, st, bp_done;
    budget = 0; stall = 0; bp_done = 0;
    n_res = 0; done_cnt = 0; t_done = -1;
    if (mode == 4) sub = 1'b1;
    cycle(1'b1, 1'b0, 0, 0, 1'b1);
    while (m_active && budget < 20000) begin
      budget++;
      a    = int'($urandom_range(0, Q-1));
      b    = int'($urandom_range(0, Q-1));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      st   = 1'b0;
      case (mode)
        0: begin
          iv = 1'b1; ordy = 1'b1;
          if (m_next == 0) begin a = 8191; b = 1; end
          else if (m_next == 1) begin a = 4096; b = 4095; end
        end
        1: begin
          iv = 1'b1; ordy = 1'b1; a = m_next; b = 2 * m_next;
        end
        2: begin
          if (m_ov && m_q[0].idx == 10 && !bp_done) begin
            if (stall < 5) begin ordy = 1'b0; stall++; end
            else begin ordy = 1'b1; bp_done = 1'b1; end
          end
        end
        3: if (m_next == 50) st = 1'b1;
        4: begin
          sub = 1'($urandom_range(0, 1));
          if (m_next == 0) begin a = 0; b = 1; end
          else if (m_next == 1) begin a = 5; b = 3; end
        end
        default: ;
      endcase
      if (rst_at >= 0 && m_next == rst_at) begin
        mid_reset();
        break;
      end
      cycle(st, iv, a, b, ordy);
    end
    cycle(1'b0, 1'b0, 0, 0, 1'b1);
    chk("busy_end", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; sub = 0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
    m_active = 0; m_ov = 0; m_done = 0; m_all_acc = 0; m_sub = 0; m_next = 0; cyc = 0;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_out_c", int'(out_c), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(0, -1);
    chk("wrap_c0", obs_c[0], 0);
    chk("wrap_c1", obs_c[1], 8191);
    chk("wrap_results", n_res, N);
    chk("wrap_done_cnt", done_cnt, 1);

    run_frame(1, -1);
    chk("full_results", n_res, N);
    chk("full_rate", t_hs[N-1] - t_hs[0], N - 1);
    chk("full_c700", obs_c[N-1], (3 * (N-1)) % Q);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_done_timing", t_done, t_hs[N-1]);

    run_frame(2, -1);
    chk("bp_results", n_res, N);
    chk("bp_done_cnt", done_cnt, 1);

    run_frame(1, 300);
    repeat (3) cycle(1'b0, 1'b1, 1, 1, 1'b1);
    chk("rst_no_done", done_cnt, 0);
    run_frame(1, -1);
    chk("restart_results", n_res, N);
    chk("restart_done_cnt", done_cnt, 1);

    run_frame(3, -1);
    chk("ign_start_results", n_res, N);
    chk("ign_start_done_cnt", done_cnt, 1);

`ifdef RQ_POLY_SUB_EN
    run_frame(4, -1);
    chk("sub_c0", obs_c[0], 8191);
    chk("sub_c1", obs_c[1], 2);
    chk("sub_results", n_res, N);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rq_poly_add_seq.md
Name: rq_poly_add_seq

Overview:
- Sequential wrapper that drives the 4-bit ripple-adder chain to add two Rq polynomials, one coefficient pair per handshake.
- Rq parameters: n = 701, q = 8192 = 2^13.
- Consumes coefficient pairs from the upstream memory/streaming stage and presents indexed sums to the downstream writeback stage.
- Reduction mod q is truncation to Q_BITS; no extra logic is needed.

Parameters:
- N, 701, number of coefficients per polynomial (frame length).
- Q_BITS, 13, coefficient width; q = 2^Q_BITS.
- IDX_W, 10, index width; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a frame; honoured only in IDLE.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at frame completion.
- in_valid  input  1  in_a/in_b hold a valid pair.
- in_ready  output  1  block accepts a pair this cycle.
- in_a  input  Q_BITS  coefficient of polynomial a.
- in_b  input  Q_BITS  coefficient of polynomial b.
- out_valid  output  1  out_* hold a valid result.
- out_ready  input  1  downstream accepts the result.
- out_c  output  Q_BITS  (a+b) mod q.
- out_idx  output  IDX_W  coefficient index of out_c.
- out_last  output  1  out_c is coefficient N-1.

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - idx = 0.
  - busy, done, in_ready, out_valid, out_last = 0.
  - out_c = 0, out_idx = 0.
  - Reset mid-frame discards the frame; no done pulse is issued.
- States: IDLE, RUN, DRAIN.
  - IDLE: in_ready = 0. start=1 -> RUN, idx <= 0.
  - RUN: in_ready = !out_valid || out_ready.
    - Accept occurs when in_valid && in_ready.
    - An accept with idx == N-1 -> DRAIN.
  - DRAIN: in_ready = 0. Output handshake with out_last=1 -> IDLE, and done = 1 for exactly the next cycle (registered).
- start outside IDLE is ignored. start in the same cycle as the done pulse (already IDLE) is honoured.
- Datapath:
  - ceil(Q_BITS/4) adder4bit instances in ripple; first cin = 0.
  - Operands are zero-extended to a multiple of 4.
  - Sum is truncated to Q_BITS; carry-out is discarded (wrap mod q).
- On accept, single output register loads:
  - out_c = sum
  - out_idx = idx
  - out_last = (idx == N-1)
  - out_valid = 1
  - idx is then incremented.
- Latency: exactly 1 cycle from accept to out_valid.
- Output hold: while out_valid && !out_ready, out_c/out_idx/out_last hold stable and in_ready = 0.
- Simultaneous events:
  - Output handshake and input accept in the same cycle: register reloads and out_valid stays 1. Full throughput is 1 coefficient/cycle.
  - Output handshake with no accept: out_valid <= 0.
- in_valid while not in RUN is ignored. in_a/in_b are don't-care when not accepted.
- idx never exceeds N-1; it does not wrap within a frame.

Optional Feature:
- Macro: RQ_POLY_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled and latched on an accepted start. It is constant for the frame.
  - sub=1 computes (a-b) mod q: in_b is inverted bitwise and the first cin = 1.
  - sub=0 computes a+b.
- Undefined: port absent; always add.

Test Plan:
- Wrap: N=701, frame with pair0 a=8191,b=1; pair1 a=4096,b=4095 -> out_c=0 idx 0; out_c=8191 idx 1.
- Full-rate frame: a=i, b=2i, in_valid and out_ready held high.
  - Required: out_c = 3i mod 8192 with out_idx = i, one result per cycle.
  - out_last only at idx 700; done pulses once, one cycle after the idx-700 handshake; busy low thereafter.
- Backpressure: out_ready=0 for 5 cycles at idx 10.
  - out_c/out_idx stay fixed at the idx-10 result and in_ready = 0.
  - On release there is no loss or duplication; idx 11 follows.
- Reset mid-frame: assert rst at idx 300.
  - out_valid, busy, in_ready go 0 immediately; no done pulse.
  - A following start restarts at out_idx 0.
- Ignored start: start pulsed during RUN at idx 50 -> no idx reset, frame completes normally with 701 results.
- RQ_POLY_SUB_EN: sub=1, a=0,b=1 -> 8191; a=5,b=3 -> 2. sub toggled mid-frame has no effect.
